out_monitor: RTL and testbench
==============================

# out_monitor

Downstream checker for the `des1` standard-cell test stage. It samples the stage's serial `out` on the shared clock and compares it against a fixed expected level. Once the stage's logic is constant, that level is 1: the XNOR of a bit and its complement is 0, and the output inverter turns that into 1. A pipeline-fill window masks start-up values. The block counts matching and mismatching cycles in saturating counters and latches a sticky FAIL after a programmable number of mismatches. It sits beside `des1` in the gate-level flow as the pass/fail observer for post-synthesis simulation.

## Interface
Parameters:
- `EXPECT`, 1, expected steady-state level of `din`.
- `FILL`, 3, number of cycles masked after enable (covers `des1` flop latency plus the input register); legal range 1..15.
- `CNT_W`, 16, width of `pass_cnt`.
- `ERR_W`, 8, width of `err_cnt`.
- `FAIL_TH`, 4, mismatch count that forces FAIL; 0 disables FAIL; must be ≤ 2^ERR_W−1.

Ports:
- `clk`  in  1  single clock, rising edge, shared with `des1`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run request; level-sensitive.
- `clr`  in  1  synchronous clear; one-cycle pulse.
- `din`  in  1  serial data from `des1` `out`.
- `state`  out  2  FSM state: 00 IDLE, 01 FILL, 10 CHECK, 11 FAIL.
- `locked`  out  1  high while in CHECK.
- `fail`  out  1  high while in FAIL.
- `err_pulse`  out  1  one-cycle pulse per mismatch.
- `err_cnt`  out  ERR_W  saturating mismatch count.
- `pass_cnt`  out  CNT_W  saturating match count.

## Operation
- Input register: `din_q` is loaded with `din` every edge. All comparisons use `din_q`, never `din` directly.
- Reset (`rst_n`=0, asynchronous) sets:
  - `state`=IDLE;
  - `din_q`, fill counter, `err_cnt`, `pass_cnt` all 0;
  - `err_pulse`, `locked`, `fail` all 0.
- Priority at each edge: reset, then `clr`, then FSM.
- `clr`=1 at an edge:
  - `state` goes to IDLE;
  - both counters and the fill counter are zeroed;
  - `err_pulse` is 0;
  - `clr` wins over `en` in the same cycle.
- FSM transitions:
  - IDLE: `en`=1 → FILL, with the fill counter loaded to FILL−1. Otherwise stay.
  - FILL: `en`=0 → IDLE. Fill counter 0 → CHECK. Otherwise decrement. No comparisons are made.
  - CHECK: `en`=0 → IDLE, with counters held, not cleared. Otherwise compare `din_q` to EXPECT:
    - match: increment `pass_cnt`;
    - mismatch: increment `err_cnt` and set `err_pulse`=1 for the next cycle;
    - if FAIL_TH≠0 and the post-increment `err_cnt` equals FAIL_TH: → FAIL on the same edge.
  - FAIL: sticky. Ignores `en` and `din`. Counters frozen. Left only by `clr` or reset.
- Saturation:
  - `pass_cnt` holds at 2^CNT_W−1.
  - `err_cnt` holds at 2^ERR_W−1. `err_pulse` still fires for every mismatch while `err_cnt` is saturated.
- Re-entering FILL from IDLE does not clear the counters; only `clr` and reset do.
- Output decode: `locked` = (`state`==CHECK); `fail` = (`state`==FAIL). Both are registered-state decodes, so they are glitch-free.

## Timing
- `en` sampled high at edge k (state IDLE) gives:
  - FILL during cycles k..k+FILL−1;
  - CHECK from edge k+FILL;
  - first comparison at edge k+FILL+1, using `din` sampled at edge k+FILL.
- `din` to counter update latency: 2 edges (input register, then compare).
- `err_pulse`, `err_cnt` update and any FAIL entry are all visible in the same cycle, directly after the comparing edge.
- `en` dropping in CHECK: a comparison at that same edge is not performed.
- Reset asserted mid-CHECK clears everything immediately, without waiting for a clock edge. The first edge after `rst_n` rises sees IDLE.

## Test plan
- Reset, then `en`=1 with `din` held at 1 for 20 cycles (EXPECT=1, FILL=3) → `locked` rises 3 cycles after `en` is sampled; `pass_cnt`=16; `err_cnt`=0; `err_pulse` never fires.
- In CHECK, inject 0 on `din` for 1 cycle at cycle 10 → exactly one `err_pulse`, 2 edges after the 0 was presented; `err_cnt`=1; `fail`=0.
- Drive `din`=0 continuously in CHECK (FAIL_TH=4) → `err_cnt` reaches 4 and `state`=11 on the same edge; later `din`=1 and toggling `en` leave counters frozen; `clr` pulse → IDLE, counters 0.
- `din`=0 during FILL only, 1 afterwards → `err_cnt` stays 0, because masked cycles are not counted.
- With CNT_W=4 run 20 matching cycles → `pass_cnt` saturates at 15. With FAIL_TH=0 and ERR_W=2, 5 mismatches → `err_cnt`=3, 5 `err_pulse`s, no FAIL.
- Assert `rst_n`=0 mid-CHECK between edges → outputs and counters go to 0 and `state` to IDLE asynchronously. Assert `clr` and `en` in the same cycle → IDLE.

Source files
------------

// File: rtl/out_monitor.sv
// -----------------------------------------------------------------------------
// out_monitor
//   Pass/fail observer for the des1 standard-cell test stage. Samples the
//   stage's serial output, masks a pipeline-fill window after enable, then
//   compares every cycle against a fixed expected level. Matches and
//   mismatches are counted in saturating counters. A sticky FAIL state is
//   entered once the mismatch count reaches FAIL_TH (0 disables FAIL).
//
// Ports
//   i_clk        rising-edge clock shared with des1
//   i_rst_n      asynchronous active-low reset
//   i_en         run request (level)
//   i_clr        synchronous clear pulse; overrides i_en
//   i_din        serial data from des1 out
//   o_state      00 IDLE, 01 FILL, 10 CHECK, 11 FAIL
//   o_locked     high while in CHECK
//   o_fail       high while in FAIL
//   o_err_pulse  one-cycle pulse per mismatch
//   o_err_cnt    saturating mismatch count
//   o_pass_cnt   saturating match count
// -----------------------------------------------------------------------------
module out_monitor #(
  parameter logic EXPECT  = 1'b1,
  parameter int   FILL    = 3,
  parameter int   CNT_W   = 16,
  parameter int   ERR_W   = 8,
  parameter int   FAIL_TH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_din,
  output logic [1:0]       o_state,
  output logic             o_locked,
  output logic             o_fail,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_CHECK = 2'b10,
    S_FAIL  = 2'b11
  } state_t;

  localparam logic [3:0]       FILL_LOAD = 4'(FILL - 1);
  localparam logic [ERR_W-1:0] FAIL_TH_V = ERR_W'(FAIL_TH);

  state_t           r_state, w_state_nxt;
  logic             r_din_q;
  logic [3:0]       r_fill, w_fill_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt, w_err_inc;
  logic [CNT_W-1:0] r_pass, w_pass_nxt, w_pass_inc;
  logic             r_pulse, w_pulse_nxt;

  // Saturating increments: hold at all-ones.
  assign w_err_inc  = (&r_err)  ? r_err  : r_err  + ERR_W'(1);
  assign w_pass_inc = (&r_pass) ? r_pass : r_pass + CNT_W'(1);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_err_nxt   = r_err;
    w_pass_nxt  = r_pass;
    w_pulse_nxt = 1'b0;

    if (i_clr) begin
      w_state_nxt = S_IDLE;
      w_fill_nxt  = '0;
      w_err_nxt   = '0;
      w_pass_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_en) begin
            w_state_nxt = S_FILL;
            w_fill_nxt  = FILL_LOAD;
          end
        end
        S_FILL: begin
          if (!i_en)                w_state_nxt = S_IDLE;
          else if (r_fill == 4'd0)  w_state_nxt = S_CHECK;
          else                      w_fill_nxt  = r_fill - 4'd1;
        end
        S_CHECK: begin
          // Dropping en returns to IDLE with counters held; no compare then.
          if (!i_en) begin
            w_state_nxt = S_IDLE;
          end else if (r_din_q == EXPECT) begin
            w_pass_nxt = w_pass_inc;
          end else begin
            w_err_nxt   = w_err_inc;
            w_pulse_nxt = 1'b1;
            if (FAIL_TH != 0 && w_err_inc == FAIL_TH_V) w_state_nxt = S_FAIL;
          end
        end
        S_FAIL: begin
          // Sticky: only clr or reset leave this state.
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_din_q <= 1'b0;
      r_fill  <= '0;
      r_err   <= '0;
      r_pass  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_din_q <= i_din;
      r_fill  <= w_fill_nxt;
      r_err   <= w_err_nxt;
      r_pass  <= w_pass_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Decodes of registered state only, so these are glitch-free.
  assign o_state     = r_state;
  assign o_locked    = (r_state == S_CHECK);
  assign o_fail      = (r_state == S_FAIL);
  assign o_err_pulse = r_pulse;
  assign o_err_cnt   = r_err;
  assign o_pass_cnt  = r_pass;

endmodule

// File: tb/tb_out_monitor.sv
// -----------------------------------------------------------------------------
// tb_out_monitor
//   Drives two out_monitor instances with identical stimulus:
//     dut_a : default configuration (CNT_W=16, ERR_W=8, FAIL_TH=4)
//     dut_b : small configuration   (CNT_W=4,  ERR_W=2, FAIL_TH=0)
//   A timeline model (age since run start, sticky failed flag, counters) is
//   compared against both every cycle, plus hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_out_monitor;

  localparam int FILL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, clr = 1'b0, din = 1'b0;

  always #5 clk = ~clk;

  logic [1:0]  a_state, b_state;
  logic        a_locked, a_fail, a_pulse;
  logic        b_locked, b_fail, b_pulse;
  logic [7:0]  a_err;
  logic [15:0] a_pass;
  logic [1:0]  b_err;
  logic [3:0]  b_pass;

  out_monitor #(.EXPECT(1'b1), .FILL(FILL), .CNT_W(16), .ERR_W(8), .FAIL_TH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_din(din),
    .o_state(a_state), .o_locked(a_locked), .o_fail(a_fail),
    .o_err_pulse(a_pulse), .o_err_cnt(a_err), .o_pass_cnt(a_pass)
  );

  out_monitor #(.EXPECT(1'b1), .FILL(FILL), .CNT_W(4), .ERR_W(2), .FAIL_TH(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr), .i_din(din),
    .o_state(b_state), .o_locked(b_locked), .o_fail(b_fail),
    .o_err_pulse(b_pulse), .o_err_cnt(b_err), .o_pass_cnt(b_pass)
  );

  int n_checks = 0;
  int n_errors = 0;
  int a_pulses = 0;
  int b_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // age: -1 idle, 0..FILL-1 masking, >=FILL checking.
  int  m_age[2];
  bit  m_failed[2];
  int  m_pass[2];
  int  m_err[2];
  bit  m_pulse[2];
  bit  m_din_q;

  function automatic int cnt_max(input int c);
    return (c == 0) ? 65535 : 15;
  endfunction
  function automatic int err_max(input int c);
    return (c == 0) ? 255 : 3;
  endfunction
  function automatic int fail_th(input int c);
    return (c == 0) ? 4 : 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_age[c] = -1; m_failed[c] = 0; m_pass[c] = 0; m_err[c] = 0; m_pulse[c] = 0;
    end
    m_din_q = 0;
  endtask

  task automatic model_edge();
    bit prev;
    prev    = m_din_q;
    m_din_q = din;
    for (int c = 0; c < 2; c++) begin
      m_pulse[c] = 0;
      if (clr) begin
        m_age[c] = -1; m_failed[c] = 0; m_pass[c] = 0; m_err[c] = 0;
      end else if (m_failed[c]) begin
        // frozen
      end else if (m_age[c] < 0) begin
        if (en) m_age[c] = 0;
      end else if (!en) begin
        m_age[c] = -1;
      end else if (m_age[c] < FILL) begin
        m_age[c]++;
      end else if (prev == 1'b1) begin
        if (m_pass[c] < cnt_max(c)) m_pass[c]++;
      end else begin
        if (m_err[c] < err_max(c)) m_err[c]++;
        m_pulse[c] = 1;
        if (fail_th(c) != 0 && m_err[c] == fail_th(c)) m_failed[c] = 1;
      end
    end
  endtask

  function automatic logic [31:0] expect_vec(input int c);
    logic [1:0] st;
    if (m_failed[c])          st = 2'b11;
    else if (m_age[c] < 0)    st = 2'b00;
    else if (m_age[c] < FILL) st = 2'b01;
    else                      st = 2'b10;
    return {st, st == 2'b10, st == 2'b11, m_pulse[c], 3'b000, 8'(m_err[c]), 16'(m_pass[c])};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      a_pulses += int'(a_pulse);
      b_pulses += int'(b_pulse);
      check("model_a", {a_state, a_locked, a_fail, a_pulse, 3'b000, a_err, a_pass}, expect_vec(0));
      check("model_b", {b_state, b_locked, b_fail, b_pulse, 3'b000, 6'b0, b_err, 12'b0, b_pass},
            expect_vec(1));
    end
  end

  // Apply inputs for one edge; return just after the following falling edge.
  task automatic cyc(input logic e, input logic c, input logic d);
    en = e; clr = c; din = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int p0, b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a", {a_state, a_locked, a_fail, a_pulse, 3'b000, a_err, a_pass}, 32'h0);
    check("rst_b", {26'b0, b_state, b_locked, b_fail, b_pulse, 1'b0}, 32'h0);
    rst_n = 1'b1;

    // T1: 20 cycles of matching data.
    p0 = a_pulses;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1);
      if (i == 2) check("t1_fill_not_locked", 32'(a_locked), 32'd0);
      if (i == 3) check("t1_locked", 32'(a_locked), 32'd1);
    end
    check("t1_pass_a", 32'(a_pass), 32'd16);
    check("t1_err_a", 32'(a_err), 32'd0);
    check("t1_no_pulse", 32'(a_pulses - p0), 32'd0);
    check("t1_pass_b_sat", 32'(b_pass), 32'd15);

    // T2: single-cycle 0 -> one pulse two edges later.
    p0 = a_pulses;
    b0 = b_pulses;
    cyc(1, 0, 0);
    check("t2_pulse_not_yet", 32'(a_pulse), 32'd0);
    cyc(1, 0, 1);
    check("t2_pulse", 32'(a_pulse), 32'd1);
    check("t2_err", 32'(a_err), 32'd1);
    cyc(1, 0, 1);
    check("t2_one_pulse", 32'(a_pulses - p0), 32'd1);
    check("t2_no_fail", 32'(a_fail), 32'd0);

    // T3: continuous 0 -> FAIL at err_cnt=4 on the same edge.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      if (i == 2) check("t3_err3_state", {24'b0, a_err}, {24'b0, 8'd3});
      if (i == 2) check("t3_still_check", 32'(a_state), 32'd2);
      if (i == 3) check("t3_fail_state", 32'(a_state), 32'd3);
      if (i == 3) check("t3_err4", 32'(a_err), 32'd4);
    end
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t3_b_err_sat", 32'(b_err), 32'd3);
    check("t3_b_pulses", 32'(b_pulses - b0), 32'd6);
    check("t3_b_no_fail", 32'(b_state), 32'd2);
    cyc(0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    check("t3_frozen_state", 32'(a_state), 32'd3);
    check("t3_frozen_err", 32'(a_err), 32'd4);
    check("t3_frozen_pass", 32'(a_pass), 32'd19);
    // clr together with en -> IDLE, counters zeroed.
    cyc(1, 1, 1);
    check("clr_a", {a_state, a_locked, a_fail, a_pulse, 3'b000, a_err, a_pass}, 32'h0);
    check("clr_b", {22'b0, b_state, b_err, b_pass}, 32'h0);

    // T4: zeros only during the fill window are masked.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1);
    check("t4_err", 32'(a_err), 32'd0);
    check("t4_pass", 32'(a_pass), 32'd7);

    // T5: asynchronous reset between edges while in CHECK.
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_a", {a_state, a_locked, a_fail, a_pulse, 3'b000, a_err, a_pass}, 32'h0);
    check("async_rst_b", {22'b0, b_state, b_err, b_pass}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 1);
    check("post_rst_idle", 32'(a_state), 32'd0);

    // T6: en drop in CHECK skips the compare; re-entry keeps counters.
    for (int i = 0; i < 5; i++) cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("t6_idle", 32'(a_state), 32'd0);
    check("t6_no_err", 32'(a_err), 32'd0);
    check("t6_pass", 32'(a_pass), 32'd2);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1);
    check("t6_reentry_pass", 32'(a_pass), 32'd4);

    cyc(0, 0, 0);
    cyc(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
